// File: rtl/instr_encoder_pkg.sv
// Shared opcode codes, encoder FSM states and MIPS field positions.
// Used by the program loader (instr_encoder) and its packer.
package instr_encoder_pkg;

    // MIPS primary opcodes
    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Pipeline stage codes
    localparam logic [2:0] STATE_IF  = 3'd0;
    localparam logic [2:0] STATE_ID  = 3'd1;
    localparam logic [2:0] STATE_EX  = 3'd2;
    localparam logic [2:0] STATE_MEM = 3'd3;
    localparam logic [2:0] STATE_WB  = 3'd4;

    // Loader FSM states
    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_LOAD,
        ENC_WRITE,
        ENC_DONE
    } enc_state_t;

    // Field LSB positions within the 32-bit word
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_LSB   = 0;
    localparam int TGT_LSB   = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [5:0]  func;
        logic [25:0] jump_target;
    } instr_fields_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        unique case (op)
            OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW:
                is_legal_op = 1'b1;
            default:
                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer for R, I and J formats.
// Fields not used by the selected format are ignored.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  instr_fields_t fields,
    output logic [31:0]   word
);

    logic is_r;
    logic is_j;

    assign is_r = (fields.opcode == OP_R);
    assign is_j = (fields.opcode == OP_J) || (fields.opcode == OP_JAL);

    // Place each field at its format position; shamt stays zero
    always_comb begin
        word = '0;
        word[OP_LSB +: 6] = fields.opcode;
        unique case (1'b1)
            is_r: begin
                word[RS_LSB +: 5]   = fields.rs;
                word[RT_LSB +: 5]   = fields.rt;
                word[RD_LSB +: 5]   = fields.rd;
                word[FUNC_LSB +: 6] = fields.func;
            end
            is_j: begin
                word[TGT_LSB +: 26] = fields.jump_target;
            end
            default: begin
                word[RS_LSB +: 5]   = fields.rs;
                word[RT_LSB +: 5]   = fields.rt;
                word[IMM_LSB +: 16] = fields.imm;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs field tuples and writes them to consecutive imem words.
// Optional ILLEGAL_OP_CHECK_EN stops the load on an opcode outside the table.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [5:0]        func,
    input  logic [25:0]       jump_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
`ifdef ILLEGAL_OP_CHECK_EN
    output logic              overflow,
    output logic              illegal_op
`else
    output logic              overflow
`endif
);

    enc_state_t    state;
    enc_state_t    state_next;
    instr_fields_t fields;
    logic [31:0]   word;
    logic          accept;
    logic          bad_op;
    logic          last_q;
    logic          at_top;
    logic          full;

    assign fields = '{
        opcode:      opcode,
        rs:          rs,
        rt:          rt,
        rd:          rd,
        imm:         imm,
        func:        func,
        jump_target: jump_target
    };

    instr_pack u_pack (
        .fields (fields),
        .word   (word)
    );

    assign in_ready = (state == ENC_LOAD);
    assign accept   = in_valid && in_ready;
    assign at_top   = &mem_addr;
    assign full     = count[ADDR_W];

`ifdef ILLEGAL_OP_CHECK_EN
    assign bad_op = !is_legal_op(opcode);
`else
    assign bad_op = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ENC_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ENC_IDLE: begin
                if (start) state_next = ENC_LOAD;
            end
            ENC_LOAD: begin
                if (accept) state_next = bad_op ? ENC_DONE : ENC_WRITE;
            end
            ENC_WRITE: begin
                if (start)                 state_next = ENC_LOAD;
                else if (last_q || at_top) state_next = ENC_DONE;
                else                       state_next = ENC_LOAD;
            end
            ENC_DONE: begin
                if (start) state_next = ENC_LOAD;
            end
            default: state_next = ENC_IDLE;
        endcase
    end

    // Address, count, write strobe and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            last_q    <= 1'b0;
`ifdef ILLEGAL_OP_CHECK_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            mem_we <= accept && !bad_op;
            unique case (state)
                ENC_IDLE: begin
                    if (start) begin
                        mem_addr <= '0;
                        count    <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                ENC_LOAD: begin
                    if (start) begin
                        mem_addr <= '0;
                        count    <= '0;
                    end
                    if (accept && !bad_op) begin
                        mem_wdata <= word;
                        last_q    <= in_last;
                    end
                    if (accept && bad_op) begin
                        done <= 1'b1;
`ifdef ILLEGAL_OP_CHECK_EN
                        illegal_op <= 1'b1;
`endif
                    end
                end
                ENC_WRITE: begin
                    if (start) begin
                        mem_addr <= '0;
                        count    <= '0;
                    end else begin
                        count <= count + (ADDR_W+1)'(1);
                        if (last_q || at_top) done <= 1'b1;
                        else mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                ENC_DONE: begin
                    if (start) begin
                        mem_addr <= '0;
                        count    <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
`ifdef ILLEGAL_OP_CHECK_EN
                        illegal_op <= 1'b0;
`endif
                    end else if (in_valid && full) begin
                        overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (default and ADDR_W=2 instances).
// Expected writes are queued at accept and checked when mem_we fires.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [5:0]  opcode = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [15:0] imm = '0;
    logic [5:0]  func = '0;
    logic [25:0] jump_target = '0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic        done;
    logic        overflow;

    logic        s_reset = 1'b1;
    logic        s_start = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_last = 1'b0;
    logic        s_in_ready;
    logic        s_mem_we;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_count;
    logic        s_done;
    logic        s_overflow;

`ifdef ILLEGAL_OP_CHECK_EN
    logic illegal_op;
    logic s_illegal_op;
`endif

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .func(func), .jump_target(jump_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done),
`ifdef ILLEGAL_OP_CHECK_EN
        .illegal_op(illegal_op),
`endif
        .overflow(overflow)
    );

    instr_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset(s_reset), .start(s_start),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_last(s_in_last),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .func(func), .jump_target(jump_target),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .count(s_count), .done(s_done),
`ifdef ILLEGAL_OP_CHECK_EN
        .illegal_op(s_illegal_op),
`endif
        .overflow(s_overflow)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] word;
        bit          chk_word;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [5:0]  func;
        logic [25:0] tgt;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_addr = '0;
    bit          prev_we = 1'b0;
    int          s_writes = 0;
    logic [1:0]  s_exp_addr = '0;

    logic [5:0] legal_ops [14] = '{
        6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
        6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B
    };

    // Scoreboard for the main instance: pop and decode each write
    exp_t m_e;
    logic m_bad;
    logic [5:0] m_op;
    always @(negedge clk) begin
        if (mem_we) begin
            total++;
            if (prev_we) begin
                bad++;
                $display("FAIL we_pulse: mem_we high two cycles, addr=%0d", mem_addr);
            end
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: write addr=%0d data=%h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                m_e = sbq.pop_front();
                if (mem_addr !== m_e.addr) begin
                    bad++;
                    $display("FAIL sb_addr: got %0d want %0d", mem_addr, m_e.addr);
                end
                if (m_e.chk_word) begin
                    total++;
                    if (mem_wdata !== m_e.word) begin
                        bad++;
                        $display("FAIL sb_word: got %h want %h", mem_wdata, m_e.word);
                    end
                end
                total++;
                m_op = mem_wdata[31:26];
                m_bad = (m_op !== m_e.op);
                if (m_e.op == 6'h00)
                    m_bad = m_bad || mem_wdata[25:21] !== m_e.rs
                          || mem_wdata[20:16] !== m_e.rt
                          || mem_wdata[15:11] !== m_e.rd
                          || mem_wdata[10:6] !== 5'd0
                          || mem_wdata[5:0] !== m_e.func;
                else if (m_e.op == 6'h02 || m_e.op == 6'h03)
                    m_bad = m_bad || mem_wdata[25:0] !== m_e.tgt;
                else
                    m_bad = m_bad || mem_wdata[25:21] !== m_e.rs
                          || mem_wdata[20:16] !== m_e.rt
                          || mem_wdata[15:0] !== m_e.imm;
                if (m_bad) begin
                    bad++;
                    $display("FAIL sb_decode: word=%h want op=%h rs=%0d rt=%0d rd=%0d imm=%h func=%h tgt=%h",
                             mem_wdata, m_e.op, m_e.rs, m_e.rt, m_e.rd,
                             m_e.imm, m_e.func, m_e.tgt);
                end
            end
        end
        prev_we = mem_we;
    end

    // Small instance: writes must land on consecutive addresses
    always @(negedge clk) begin
        if (s_mem_we) begin
            s_writes++;
            total++;
            if (s_mem_addr !== s_exp_addr) begin
                bad++;
                $display("FAIL s_addr: got %0d want %0d", s_mem_addr, s_exp_addr);
            end
            s_exp_addr = s_exp_addr + 2'd1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c,
                        input logic [15:0] im, input logic [5:0] fn,
                        input logic [25:0] tg, input bit last,
                        input bit chk, input logic [31:0] w);
        int n;
        exp_t e;
        @(negedge clk);
        opcode = op; rs = a; rt = b; rd = c;
        imm = im; func = fn; jump_target = tg;
        in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
            in_valid = 1'b0;
            in_last = 1'b0;
            return;
        end
        e = '{addr: exp_addr, word: w, chk_word: chk, op: op, rs: a,
              rt: b, rd: c, imm: im, func: fn, tgt: tg};
        exp_addr = exp_addr + 8'd1;
        @(posedge clk);
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_write: in_ready=%b want 0", in_ready);
        end
    endtask

    task automatic send_rand(input bit last);
        logic [5:0] op;
        op = legal_ops[$urandom_range(0, 13)];
        send(op, 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 6'($urandom), 26'($urandom), last, 1'b0, '0);
    endtask

    task automatic wait_done(input logic [8:0] want_count, input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: done=%b want 1", tag, done);
        end
        total++;
        if (count !== want_count) begin
            bad++;
            $display("FAIL %s_count: count=%0d want %0d", tag, count, want_count);
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: %0d expected writes never seen", tag, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, mem_we, done, overflow} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready/we/done/ovf=%b want 0000",
                     {in_ready, mem_we, done, overflow});
        end
        total++;
        if ({mem_addr, mem_wdata, count} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d wdata=%h count=%0d want 0",
                     mem_addr, mem_wdata, count);
        end
        reset = 1'b0;
        s_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encodings();
        pulse_start();
        send(6'h00, 5'd1, 5'd2, 5'd3, 16'hABCD, 6'h20, 26'h155_5555,
             1'b1, 1'b1, 32'h0022_1820);
        wait_done(9'd1, "r_type");
        pulse_start();
        send(6'h08, 5'd1, 5'd2, 5'd9, 16'hFFFF, 6'h3F, 26'h2AA_AAAA,
             1'b1, 1'b1, 32'h2022_FFFF);
        wait_done(9'd1, "i_type");
        pulse_start();
        send(6'h03, 5'd5, 5'd6, 5'd7, 16'h1234, 6'h05, 26'h000_0010,
             1'b1, 1'b1, 32'h0C00_0010);
        wait_done(9'd1, "jal");
        pulse_start();
        send(6'h02, 5'd31, 5'd31, 5'd31, 16'hFFFF, 6'h3F, 26'h3FF_FFFF,
             1'b1, 1'b1, 32'h0BFF_FFFF);
        wait_done(9'd1, "j_type");
    endtask

    task automatic test_program();
        pulse_start();
        send_rand(1'b0);
        send_rand(1'b0);
        send_rand(1'b1);
        wait_done(9'd3, "prog3");
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_done: in_ready=%b want 0", in_ready);
        end
        total++;
        if (mem_addr !== 8'd2) begin
            bad++;
            $display("FAIL prog3_addr_hold: addr=%0d want 2", mem_addr);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        send_rand(1'b0);
        send_rand(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = '0;
        total++;
        if (mem_addr !== 8'd0 || count !== 9'd0) begin
            bad++;
            $display("FAIL restart_clear: addr=%0d count=%0d want 0 0", mem_addr, count);
        end
        send_rand(1'b1);
        wait_done(9'd1, "restart");
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_rand(1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({in_ready, mem_we, done, overflow, mem_addr, mem_wdata, count} !== '0) begin
            bad++;
            $display("FAIL reset_mid: ready=%b we=%b done=%b ovf=%b addr=%0d wdata=%h count=%0d want all 0",
                     in_ready, mem_we, done, overflow, mem_addr, mem_wdata, count);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || count !== 9'd0) begin
            bad++;
            $display("FAIL idle_ignores_valid: ready=%b count=%0d want 0 0", in_ready, count);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        s_writes = 0;
        s_exp_addr = '0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_in_valid = 1'b1;
        n = 0;
        while (!s_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (s_done !== 1'b1) begin
            bad++;
            $display("FAIL full_done: done=%b want 1", s_done);
        end
        total++;
        if (s_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early: overflow=%b want 0", s_overflow);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (s_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: overflow=%b want 1", s_overflow);
        end
        total++;
        if (s_count !== 3'd4 || s_writes != 4) begin
            bad++;
            $display("FAIL full_count: count=%0d writes=%0d want 4 4", s_count, s_writes);
        end
        total++;
        if (s_mem_addr !== 2'd3) begin
            bad++;
            $display("FAIL full_addr: addr=%0d want 3", s_mem_addr);
        end
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        total++;
        if ({s_overflow, s_done, s_count, s_mem_addr} !== '0 || s_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_from_full: ovf=%b done=%b count=%0d addr=%0d ready=%b want 0 0 0 0 1",
                     s_overflow, s_done, s_count, s_mem_addr, s_in_ready);
        end
    endtask

    task automatic test_round_trip();
        pulse_start();
        for (int i = 0; i < 24; i++) send_rand(i == 23);
        wait_done(9'd24, "round_trip");
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_program();
        test_restart();
        test_reset_mid();
        test_overflow();
        test_round_trip();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
